// File: rtl/clk_sw_pkg.sv
// rtl/clk_sw_pkg.sv - shared types and constants for the clock-switch sequencer
package clk_sw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GATE_OFF,
        LOCK_WAIT,
        MUX_SW,
        UNGATE,
        DONE,
        ERR
    } state_t;

    localparam logic SRC_PLL = 1'b0;
    localparam logic SRC_EXT = 1'b1;

    // wide enough for the largest lock timeout
    localparam int CNT_W = 10;

    function automatic logic [CNT_W-1:0] wait_load(input int cycles);
        return CNT_W'(cycles);
    endfunction

endpackage

// File: rtl/clk_sw_wait_cnt.sv
// rtl/clk_sw_wait_cnt.sv - loadable down-counter shared by the wait and timeout phases
module clk_sw_wait_cnt
    import clk_sw_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] value,
    output logic             expire
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (dec) begin
            value <= value - CNT_W'(1);
        end
    end

    // a load of N expires on the Nth edge after the load
    assign expire = (value <= CNT_W'(1));

endmodule

// File: rtl/clk_switch_seq.sv
// rtl/clk_switch_seq.sv - glitch-safe clock source switch sequencer (optional CLK_SW_LOCK_TIMEOUT_EN)
module clk_switch_seq
    import clk_sw_pkg::*;
#(
    parameter int GATE_WAIT    = 4,
    parameter int MUX_WAIT     = 4,
    parameter int LOCK_TIMEOUT = 1023
) (
    input  logic osc_clk,
    input  logic func_rst,
    input  logic sw_req,
    input  logic sw_sel,
    input  logic pll_lock,
    output logic sw_ready,
    output logic sw_done,
    output logic sw_err,
    output logic pll_cg_en,
    output logic sys_cg_en,
    output logic clkmux_sel
);

    localparam logic [CNT_W-1:0] GATE_LD = wait_load(GATE_WAIT);
    localparam logic [CNT_W-1:0] MUX_LD  = wait_load(MUX_WAIT);
    localparam logic [CNT_W-1:0] LOCK_LD = wait_load(LOCK_TIMEOUT);

    state_t           state, state_d;
    logic             tgt, tgt_d;
    logic             clkmux_d, pll_d, sys_d, done_d;
    logic             cnt_load, cnt_dec, cnt_expire;
    logic [CNT_W-1:0] cnt_ld_val, cnt_value;

`ifdef CLK_SW_LOCK_TIMEOUT_EN
    logic err_q, err_d;
`endif

    clk_sw_wait_cnt u_wait_cnt (
        .clk        (osc_clk),
        .rst        (func_rst),
        .load       (cnt_load),
        .dec        (cnt_dec),
        .load_value (cnt_ld_val),
        .value      (cnt_value),
        .expire     (cnt_expire)
    );

    assign cnt_dec  = (cnt_value != '0);
    assign sw_ready = (state == IDLE);

    always_comb begin
        state_d    = state;
        tgt_d      = tgt;
        clkmux_d   = clkmux_sel;
        pll_d      = pll_cg_en;
        sys_d      = sys_cg_en;
        cnt_load   = 1'b0;
        cnt_ld_val = GATE_LD;
`ifdef CLK_SW_LOCK_TIMEOUT_EN
        err_d      = err_q;
`endif
        case (state)
            IDLE: begin
                if (sw_req) begin
                    tgt_d = sw_sel;
                    if (sw_sel == clkmux_sel) begin
                        state_d = DONE;
                    end else begin
                        state_d  = GATE_OFF;
                        sys_d    = 1'b0;
                        cnt_load = 1'b1;
                        if (sw_sel == SRC_PLL) pll_d = 1'b1;
                    end
                end
            end
            GATE_OFF: begin
                if (cnt_expire) begin
                    cnt_load = 1'b1;
                    if (tgt == SRC_PLL) begin
                        state_d    = LOCK_WAIT;
                        cnt_ld_val = LOCK_LD;
                    end else begin
                        state_d    = MUX_SW;
                        clkmux_d   = tgt;
                        cnt_ld_val = MUX_LD;
                    end
                end
            end
            LOCK_WAIT: begin
                if (pll_lock) begin
                    state_d    = MUX_SW;
                    clkmux_d   = tgt;
                    cnt_load   = 1'b1;
                    cnt_ld_val = MUX_LD;
                end
`ifdef CLK_SW_LOCK_TIMEOUT_EN
                else if (cnt_expire) begin
                    // give up: park the PLL, reopen the gate on the unchanged source
                    state_d = ERR;
                    pll_d   = 1'b0;
                    sys_d   = 1'b1;
                    err_d   = 1'b1;
                end
`endif
            end
            MUX_SW: begin
                if (cnt_expire) begin
                    state_d = UNGATE;
                    sys_d   = 1'b1;
                    if (tgt == SRC_EXT) pll_d = 1'b0;
                end
            end
            UNGATE:  state_d = DONE;
            DONE:    state_d = IDLE;
`ifdef CLK_SW_LOCK_TIMEOUT_EN
            ERR:     state_d = DONE;
`endif
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DONE);
    end

    always_ff @(posedge osc_clk) begin
        if (func_rst) begin
            state      <= IDLE;
            tgt        <= SRC_PLL;
            clkmux_sel <= SRC_PLL;
            pll_cg_en  <= 1'b1;
            sys_cg_en  <= 1'b1;
            sw_done    <= 1'b0;
        end else begin
            state      <= state_d;
            tgt        <= tgt_d;
            clkmux_sel <= clkmux_d;
            pll_cg_en  <= pll_d;
            sys_cg_en  <= sys_d;
            sw_done    <= done_d;
        end
    end

`ifdef CLK_SW_LOCK_TIMEOUT_EN
    always_ff @(posedge osc_clk) begin
        if (func_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign sw_err = err_q;
`else
    assign sw_err = 1'b0;
`endif

endmodule

// File: tb/tb_clk_switch_seq.sv
// tb/tb_clk_switch_seq.sv - self-checking bench for clk_switch_seq
module tb_clk_switch_seq;

    localparam int G = 4;
    localparam int M = 4;
    localparam int T = 16;
    localparam int NV = 17;

    logic osc_clk = 1'b0;
    logic func_rst, sw_req, sw_sel, pll_lock;
    logic sw_ready, sw_done, sw_err, pll_cg_en, sys_cg_en, clkmux_sel;

    int checks = 0;
    int errors = 0;

    clk_switch_seq #(
        .GATE_WAIT    (G),
        .MUX_WAIT     (M),
        .LOCK_TIMEOUT (T)
    ) dut (
        .osc_clk    (osc_clk),
        .func_rst   (func_rst),
        .sw_req     (sw_req),
        .sw_sel     (sw_sel),
        .pll_lock   (pll_lock),
        .sw_ready   (sw_ready),
        .sw_done    (sw_done),
        .sw_err     (sw_err),
        .pll_cg_en  (pll_cg_en),
        .sys_cg_en  (sys_cg_en),
        .clkmux_sel (clkmux_sel)
    );

    always #5 osc_clk = ~osc_clk;

    // expected vector bit order: ready, done, mux, pll, sys, err
    typedef struct {
        bit       rst;
        bit       req;
        bit       sel;
        bit [5:0] exp;
    } vec_t;

    vec_t vecs [NV];

    // reference model: a request is a timeline measured from its handshake edge
    int cyc, e0, lock_edge, err_edge, kind;
    bit busy, src, tgt, m_err;

    function automatic logic [5:0] outs();
        return {sw_ready, sw_done, clkmux_sel, pll_cg_en, sys_cg_en, sw_err};
    endfunction

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s got %b expected %b (ready,done,mux,pll,sys,err) t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge osc_clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!sw_ready && n < 100) begin
            tick();
            n++;
        end
        check(name, {5'b0, sw_ready}, 6'd1);
    endtask

    task automatic go_ext();
        func_rst = 1'b1; sw_req = 1'b0; pll_lock = 1'b0;
        tick();
        func_rst = 1'b0; sw_req = 1'b1; sw_sel = 1'b1;
        tick();
        sw_req = 1'b0;
        wait_ready("go_ext_ready");
    endtask

    function automatic int done_edge();
        if (kind == 0) return e0;
        if (kind == 1) return e0 + G + M + 1;
        if (lock_edge >= 0) return lock_edge + M + 1;
        if (err_edge >= 0) return err_edge + 1;
        return -1;
    endfunction

    task automatic model_edge(input bit r, input bit q, input bit s, input bit l);
        if (r) begin
            busy = 1'b0; src = 1'b0; m_err = 1'b0;
        end else if (busy) begin
            if (kind == 2 && lock_edge < 0 && err_edge < 0 && cyc >= e0 + G + 1) begin
                if (l) lock_edge = cyc;
`ifdef CLK_SW_LOCK_TIMEOUT_EN
                else if (cyc == e0 + G + T) begin
                    err_edge = cyc;
                    m_err = 1'b1;
                end
`endif
            end
            if (done_edge() >= 0 && cyc == done_edge() + 1) begin
                busy = 1'b0;
                if (err_edge < 0) src = tgt;
            end
        end else if (q) begin
            busy = 1'b1; e0 = cyc; tgt = s; lock_edge = -1; err_edge = -1;
            kind = (s == src) ? 0 : (s ? 1 : 2);
        end
    endtask

    function automatic logic [5:0] model_out();
        int  k;
        bit  mux, pll, sys, done;
        if (!busy) return {1'b1, 1'b0, src, ~src, 1'b1, m_err};
        k = cyc - e0;
        done = (cyc == done_edge());
        if (kind == 0) begin
            mux = src; pll = ~src; sys = 1'b1;
        end else if (kind == 1) begin
            mux = (k >= G); sys = (k >= G + M); pll = !(k >= G + M);
        end else if (err_edge >= 0 && cyc >= err_edge) begin
            mux = 1'b1; pll = 1'b0; sys = 1'b1;
        end else begin
            mux = !(lock_edge >= 0 && cyc >= lock_edge);
            pll = 1'b1;
            sys = (lock_edge >= 0 && cyc >= lock_edge + M);
        end
        return {1'b0, done, mux, pll, sys, m_err};
    endfunction

    initial begin
        int bad;
        int lh;
        bit r, q, s, l;

        func_rst = 1'b1; sw_req = 1'b0; sw_sel = 1'b0; pll_lock = 1'b0;

        // reset, EXT switch with requests hammered while busy, same-source, reset vs request
        vecs = '{
            '{1'b1, 1'b0, 1'b0, 6'b100110},
            '{1'b0, 1'b1, 1'b1, 6'b000100},
            '{1'b0, 1'b1, 1'b0, 6'b000100},
            '{1'b0, 1'b1, 1'b0, 6'b000100},
            '{1'b0, 1'b1, 1'b0, 6'b000100},
            '{1'b0, 1'b1, 1'b0, 6'b001100},
            '{1'b0, 1'b1, 1'b0, 6'b001100},
            '{1'b0, 1'b1, 1'b0, 6'b001100},
            '{1'b0, 1'b1, 1'b0, 6'b001100},
            '{1'b0, 1'b1, 1'b0, 6'b001010},
            '{1'b0, 1'b1, 1'b0, 6'b011010},
            '{1'b0, 1'b1, 1'b0, 6'b101010},
            '{1'b0, 1'b1, 1'b1, 6'b011010},
            '{1'b0, 1'b0, 1'b0, 6'b101010},
            '{1'b1, 1'b1, 1'b1, 6'b100110},
            '{1'b0, 1'b1, 1'b0, 6'b010110},
            '{1'b0, 1'b0, 1'b0, 6'b100110}
        };
        for (int i = 0; i < NV; i++) begin
            func_rst = vecs[i].rst; sw_req = vecs[i].req; sw_sel = vecs[i].sel;
            tick();
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // EXT -> PLL with a late lock
`ifdef CLK_SW_LOCK_TIMEOUT_EN
        lh = 10;
`else
        lh = 20;
`endif
        go_ext();
        sw_req = 1'b1; sw_sel = 1'b0; pll_lock = 1'b0;
        tick();
        sw_req = 1'b0; sw_sel = 1'b1;
        check("pll_k0", outs(), 6'b001100);
        bad = 0;
        for (int k = 1; k <= lh; k++) begin
            tick();
            if (outs() !== 6'b001100) bad++;
        end
        check("pll_hold_mux", 6'(bad), 6'd0);
        pll_lock = 1'b1;
        tick();
        pll_lock = 1'b0;
        check("pll_mux_flip", outs(), 6'b000100);
        bad = 0;
        for (int k = 1; k < M; k++) begin
            tick();
            if (outs() !== 6'b000100) bad++;
        end
        check("pll_gate_hold", 6'(bad), 6'd0);
        tick();
        check("pll_ungate", outs(), 6'b000110);
        tick();
        check("pll_done", outs(), 6'b010110);
        tick();
        check("pll_idle", outs(), 6'b100110);

        // reset while in MUX_SW
        func_rst = 1'b1;
        tick();
        func_rst = 1'b0; sw_req = 1'b1; sw_sel = 1'b1;
        tick();
        sw_req = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        check("mux_sw_state", outs(), 6'b001100);
        func_rst = 1'b1;
        tick();
        func_rst = 1'b0;
        check("rst_abort", outs(), 6'b100110);
        tick();
        check("rst_no_done", outs(), 6'b100110);

`ifdef CLK_SW_LOCK_TIMEOUT_EN
        go_ext();
        sw_req = 1'b1; sw_sel = 1'b0; pll_lock = 1'b0;
        tick();
        sw_req = 1'b0;
        for (int k = 1; k < G + T; k++) tick();
        check("to_before", outs(), 6'b001100);
        tick();
        check("to_err", outs(), 6'b001011);
        tick();
        check("to_done", outs(), 6'b011011);
        tick();
        check("to_idle", outs(), 6'b101011);
        sw_req = 1'b1; sw_sel = 1'b1;
        tick();
        sw_req = 1'b0;
        check("to_sticky", outs(), 6'b011011);
        func_rst = 1'b1;
        tick();
        func_rst = 1'b0;
        check("to_rst_clear", outs(), 6'b100110);
`endif

        // randomized run against the timeline model
        cyc = 0; busy = 1'b0; src = 1'b0; m_err = 1'b0; kind = 0;
        e0 = 0; lock_edge = -1; err_edge = -1; tgt = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            r = (n == 0) || ($urandom_range(0, 199) == 0);
            q = ($urandom_range(0, 3) == 0);
            s = 1'($urandom_range(0, 1));
            l = ($urandom_range(0, 7) == 0);
            func_rst = r; sw_req = q; sw_sel = s; pll_lock = l;
            tick();
            model_edge(r, q, s, l);
            check("rand", outs(), model_out());
            cyc++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_switch_seq.md
Name: clk_switch_seq

Overview:
- Sequencer for the clock-source mux and clock gates on the lab clocking datapath.
- Runs on the always-on oscillator clock.
- Accepts a source-switch request (PLL vs external) and drives pll_cg_en, sys_cg_en and clkmux_sel in a glitch-safe order:
  - gate the downstream clock;
  - enable the PLL and wait for lock if needed;
  - flip the mux;
  - ungate.
- Replaces hand-timed toggling of these controls.

Parameters:
- GATE_WAIT, 4, osc_clk cycles sys_cg_en is held low before mux/lock step (legal 1..255)
- MUX_WAIT, 4, osc_clk cycles after clkmux_sel change before ungating (legal 1..255)
- LOCK_TIMEOUT, 1023, max osc_clk cycles waiting for pll_lock (used only with optional feature)

Ports:
- osc_clk  in  1  controller clock (always-on oscillator)
- func_rst  in  1  reset, synchronous, active-high
- sw_req  in  1  switch request, qualified by sw_ready
- sw_sel  in  1  target source, 0 = PLL, 1 = EXT; sampled on handshake
- pll_lock  in  1  PLL locked, already synchronised to osc_clk
- sw_ready  out  1  high in IDLE; handshake = sw_req && sw_ready
- sw_done  out  1  one-cycle pulse at end of every accepted request
- sw_err  out  1  sticky lock-timeout flag
- pll_cg_en  out  1  PLL clock-gate enable
- sys_cg_en  out  1  downstream system clock-gate enable
- clkmux_sel  out  1  mux select, 0 = PLL, 1 = EXT

Behaviour:
- Reset (sync, func_rst=1 at a rising edge):
  - state IDLE, clkmux_sel=0, pll_cg_en=1, sys_cg_en=1, sw_done=0, sw_err=0.
  - Reset wins over any simultaneous sw_req.
  - Reset mid-sequence aborts immediately to these values.
- All outputs are registered except sw_ready (= state==IDLE).
- State machine:
  - IDLE: on handshake at edge E0, capture tgt=sw_sel.
    - tgt==clkmux_sel → DONE; no control change.
    - else → GATE_OFF: sys_cg_en<=0; if tgt=PLL also pll_cg_en<=1. Load counter with GATE_WAIT.
  - GATE_OFF: count down. On expiry:
    - tgt=PLL → LOCK_WAIT;
    - else → MUX_SW with clkmux_sel<=tgt, counter loaded with MUX_WAIT.
  - LOCK_WAIT: stay until pll_lock=1, then MUX_SW with clkmux_sel<=tgt and counter loaded with MUX_WAIT. pll_lock already high on entry → one cycle in LOCK_WAIT.
  - MUX_SW: count down. On expiry → UNGATE: sys_cg_en<=1; if tgt=EXT, pll_cg_en<=0.
  - UNGATE: one cycle → DONE.
  - DONE: sw_done=1 for exactly this cycle → IDLE.
- Latency, EXT target, defaults (handshake at edge E0):
  - sys_cg_en low for edges E0..E0+8;
  - clkmux_sel changes after E0+4;
  - sw_done high in cycle after E0+9;
  - sw_ready high after E0+10.
- Same-source request: sw_done in cycle after E0; sw_ready after E0+1.
- Invariants:
  - clkmux_sel never changes while sys_cg_en=1.
  - pll_cg_en never falls while clkmux_sel=0.
- sw_req while not ready is ignored; it is not queued.
- sw_sel is don't-care outside the handshake.
- pll_lock deasserting outside LOCK_WAIT is ignored.

Optional Feature:
- Macro CLK_SW_LOCK_TIMEOUT_EN.
- Defined:
  - LOCK_WAIT counts cycles from entry.
  - After LOCK_TIMEOUT cycles without lock → ERR: pll_cg_en<=0, sys_cg_en<=1, clkmux_sel unchanged, sw_err<=1 (sticky until reset) → DONE (sw_done pulses).
- Undefined: LOCK_WAIT waits indefinitely; sw_err tied 0; ERR state absent.

Decomposition:
- Package clk_sw_pkg:
  - state enum (IDLE, GATE_OFF, LOCK_WAIT, MUX_SW, UNGATE, DONE, ERR);
  - SRC_PLL=1'b0, SRC_EXT=1'b1;
  - counter width constant (10 bits, covering LOCK_TIMEOUT).
- One sub-module, clk_sw_wait_cnt: loadable down-counter with load, value, expire outputs. Sync reset to 0. Shared by the wait and timeout phases.

Test Plan:
- Reset then sw_req=1, sw_sel=1 at E0, defaults → sys_cg_en=0 over E0..E0+8, clkmux_sel=1 after E0+4, pll_cg_en=0 after E0+8, sw_done pulse after E0+9.
- From EXT, request PLL with pll_lock held 0 for 20 cycles then 1 → pll_cg_en=1 after E0, clkmux_sel stays 1 until lock, flips to 0 one edge after lock seen, sys_cg_en=1 four cycles later, sw_done one pulse.
- Request sw_sel=0 while clkmux_sel=0 → sw_done after E0 only; pll_cg_en, sys_cg_en, clkmux_sel never toggle.
- sw_req asserted in every cycle during a sequence → exactly one sw_done per sw_ready handshake; no extra switches.
- func_rst=1 while in MUX_SW → next edge: clkmux_sel=0, pll_cg_en=1, sys_cg_en=1, sw_ready=1, no sw_done.
- With CLK_SW_LOCK_TIMEOUT_EN and LOCK_TIMEOUT=16, PLL request with pll_lock=0 → after 16 LOCK_WAIT cycles sw_err=1 (sticky), pll_cg_en=0, clkmux_sel=1, sys_cg_en=1, sw_done pulses.
